// File: rtl/adc_sample_sequencer_if.sv
// ADC conversion handshake (to the SPI master) and sample stream (to the consumer).
// The sequencer uses the master view; the SPI master model and sample consumer use the slave view.
interface adc_sample_sequencer_if;
  logic        ADC_ENA;
  logic [15:0] ADC_DATA_MOSI;
  logic        ADC_FIN;
  logic [15:0] ADC_DATA_MISO;
  logic [15:0] SAMPLE_DATA;
  logic [2:0]  SAMPLE_CH;
  logic        SAMPLE_VALID;
  logic        SAMPLE_READY;

  modport master (
    output ADC_ENA,
    output ADC_DATA_MOSI,
    input  ADC_FIN,
    input  ADC_DATA_MISO,
    output SAMPLE_DATA,
    output SAMPLE_CH,
    output SAMPLE_VALID,
    input  SAMPLE_READY
  );

  modport slave (
    input  ADC_ENA,
    input  ADC_DATA_MOSI,
    output ADC_FIN,
    output ADC_DATA_MISO,
    input  SAMPLE_DATA,
    input  SAMPLE_CH,
    input  SAMPLE_VALID,
    output SAMPLE_READY
  );
endinterface

// File: rtl/adc_sample_sequencer.sv
// Periodic round-robin ADC sampler: a tick launches one SPI conversion, the result and its
// channel land in a show-ahead FIFO, and sticky flags report overruns, late ticks and FIN timeouts.
module adc_sample_sequencer #(
  parameter int SAMPLE_DIV = 260,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                          SYS_CLK,
  input  logic                          RSTbar,
  input  logic                          RUN,
  input  logic                          CLR_FLAGS,
  adc_sample_sequencer_if.master        bus,
  output logic [4:0]                    FIFO_COUNT,
  output logic                          OVERRUN,
  output logic                          LATE,
  output logic                          TIMEOUT_ERR
);

  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(SAMPLE_DIV - 1);
  localparam logic [TW-1:0] DWELL_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]    CH_LAST    = 3'(NUM_CH - 1);
  localparam logic [4:0]    DEPTH      = 5'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_FIN = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic [TW-1:0]   dwell_cnt;
  logic            dwell_expired;
  logic [2:0]      ch_q;
  logic [15:0]     mosi_q;
  logic            load_cmd;
  logic            fifo_wr;
  logic            ch_advance;
  logic            timeout_set;
  logic            late_set;
  logic            overrun_set;

  logic [15:0]     data_mem [FIFO_DEPTH];
  logic [2:0]      ch_mem   [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [4:0]      count_q;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  // Sample-period counter; held at zero while stopped so the first tick after RUN rises
  // comes a full period later.
  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      div_cnt <= '0;
    end else if (!RUN) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign tick = RUN && (div_cnt == DIV_LAST);

  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Dwell restarts on every state change, so each FIN wait gets its own TIMEOUT budget.
  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      dwell_cnt <= '0;
    end else if (state_q != state_d) begin
      dwell_cnt <= '0;
    end else if ((state_q == WAIT_FIN) || (state_q == RELEASE)) begin
      dwell_cnt <= dwell_cnt + TW'(1);
    end
  end

  assign dwell_expired = (dwell_cnt == DWELL_LAST);

  always_comb begin
    state_d     = state_q;
    load_cmd    = 1'b0;
    fifo_wr     = 1'b0;
    ch_advance  = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          load_cmd = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        state_d = WAIT_FIN;
      end
      WAIT_FIN: begin
        if (bus.ADC_FIN) begin
          fifo_wr = 1'b1;
          state_d = RELEASE;
        end else if (dwell_expired) begin
          timeout_set = 1'b1;
          state_d     = IDLE;
        end
      end
      RELEASE: begin
        if (!bus.ADC_FIN) begin
          ch_advance = 1'b1;
          state_d    = IDLE;
        end else if (dwell_expired) begin
          timeout_set = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Decoded straight from the state register so an asynchronous reset drops it at once.
  assign bus.ADC_ENA       = (state_q == REQ) || (state_q == WAIT_FIN);
  assign bus.ADC_DATA_MOSI = mosi_q;
  assign late_set          = tick && (state_q != IDLE);

  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      mosi_q <= '0;
      ch_q   <= '0;
    end else begin
      if (load_cmd) begin
        mosi_q <= {2'b00, ch_q, 11'd0};
      end
      if (ch_advance) begin
        ch_q <= (ch_q == CH_LAST) ? 3'd0 : ch_q + 3'd1;
      end
    end
  end

  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign fifo_full   = (count_q == DEPTH);
  assign fifo_empty  = (count_q == 5'd0);
  assign pop         = !fifo_empty && bus.SAMPLE_READY;
  assign push        = fifo_wr && (!fifo_full || pop);
  assign overrun_set = fifo_wr && fifo_full && !pop;

  always_ff @(posedge SYS_CLK) begin
    if (push) begin
      data_mem[wr_ptr] <= bus.ADC_DATA_MISO;
      ch_mem[wr_ptr]   <= ch_q;
    end
  end

  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Memory is not reset; the outputs are forced to zero while the FIFO is empty.
  assign bus.SAMPLE_VALID = !fifo_empty;
  assign bus.SAMPLE_DATA  = fifo_empty ? 16'd0 : data_mem[rd_ptr];
  assign bus.SAMPLE_CH    = fifo_empty ? 3'd0 : ch_mem[rd_ptr];
  assign FIFO_COUNT       = count_q;

  // A flag event in the same cycle as CLR_FLAGS keeps the flag set.
  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      OVERRUN     <= 1'b0;
      LATE        <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      OVERRUN     <= overrun_set | (OVERRUN & ~CLR_FLAGS);
      LATE        <= late_set | (LATE & ~CLR_FLAGS);
      TIMEOUT_ERR <= timeout_set | (TIMEOUT_ERR & ~CLR_FLAGS);
    end
  end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Bench for adc_sample_sequencer: SPI master model plus a queue of expected FIFO contents
// that is checked against the sample outputs every cycle.
module tb_adc_sample_sequencer;

  localparam int DEPTH = 16;

  logic        SYS_CLK = 1'b0;
  logic        RSTbar;
  logic        RUN;
  logic        CLR_FLAGS;
  logic [4:0]  FIFO_COUNT;
  logic        OVERRUN;
  logic        LATE;
  logic        TIMEOUT_ERR;

  adc_sample_sequencer_if bus();

  adc_sample_sequencer #(
    .SAMPLE_DIV(260),
    .NUM_CH(2),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT(255)
  ) dut (
    .SYS_CLK(SYS_CLK),
    .RSTbar(RSTbar),
    .RUN(RUN),
    .CLR_FLAGS(CLR_FLAGS),
    .bus(bus),
    .FIFO_COUNT(FIFO_COUNT),
    .OVERRUN(OVERRUN),
    .LATE(LATE),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [18:0] exp_q[$];
  logic [15:0] miso_q[$];
  logic [15:0] next_data = 16'h1000;
  int          ena_t[$];
  int          ena_rises = 0;
  int          conv_fin = 0;
  int          bm_st = 0;
  int          bm_cnt = 0;
  int          bm_rel = 0;
  logic [2:0]  bm_ch = 3'd0;
  int          fin_delay = 3;
  int          rel_hold = 1;
  bit          fin_hang = 1'b0;
  bit          sync_pop = 1'b0;
  bit          rdy_pulse = 1'b0;
  bit          exp_overrun = 1'b0;

  always @(posedge SYS_CLK) cyc++;

  // Negedge environment: scoreboard check, consumer pops, then the SPI master model.
  always @(negedge SYS_CLK) begin : env
    logic [15:0] d;
    if (!RSTbar) begin
      exp_q.delete();
      bm_st = 0; bm_cnt = 0; bm_rel = 0; bm_ch = 3'd0;
      exp_overrun = 1'b0;
      bus.ADC_FIN = 1'b0;
      if (rdy_pulse) begin bus.SAMPLE_READY = 1'b0; rdy_pulse = 1'b0; end
    end else begin
      if (rdy_pulse) begin bus.SAMPLE_READY = 1'b0; rdy_pulse = 1'b0; end
      checks++;
      if (FIFO_COUNT !== 5'(exp_q.size())) begin
        errors++; $display("[TB] FAIL fifo_count t=%0d actual=%0d expected=%0d", cyc, FIFO_COUNT, exp_q.size());
      end
      checks++;
      if (bus.SAMPLE_VALID !== (exp_q.size() != 0)) begin
        errors++; $display("[TB] FAIL sample_valid t=%0d actual=%b expected=%b", cyc, bus.SAMPLE_VALID, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if ({bus.SAMPLE_CH, bus.SAMPLE_DATA} !== exp_q[0]) begin
          errors++; $display("[TB] FAIL head_sample t=%0d actual=%h/%h expected=%h/%h", cyc, bus.SAMPLE_CH, bus.SAMPLE_DATA, exp_q[0][18:16], exp_q[0][15:0]);
        end
      end
      checks++;
      if (OVERRUN !== exp_overrun) begin
        errors++; $display("[TB] FAIL overrun t=%0d actual=%b expected=%b", cyc, OVERRUN, exp_overrun);
      end
      if (bus.SAMPLE_READY && exp_q.size() != 0) void'(exp_q.pop_front());
      if (CLR_FLAGS) exp_overrun = 1'b0;
      if (bm_st == 0) begin
        if (bus.ADC_ENA) begin
          bm_cnt++;
          if (bm_cnt == 1) begin
            ena_rises++;
            ena_t.push_back(cyc);
            checks++;
            if (bus.ADC_DATA_MOSI !== {2'b00, bm_ch, 11'd0}) begin
              errors++; $display("[TB] FAIL mosi_cmd actual=%h expected=%h", bus.ADC_DATA_MOSI, {2'b00, bm_ch, 11'd0});
            end
          end
          if (!fin_hang && bm_cnt >= fin_delay) begin
            if (miso_q.size() != 0) d = miso_q.pop_front();
            else begin d = next_data; next_data = next_data + 16'd1; end
            bus.ADC_DATA_MISO = d;
            bus.ADC_FIN = 1'b1;
            bm_st = 1; bm_rel = 0;
            conv_fin++;
            if (sync_pop && exp_q.size() != 0 && !bus.SAMPLE_READY) begin
              bus.SAMPLE_READY = 1'b1; rdy_pulse = 1'b1;
              void'(exp_q.pop_front());
            end
            if (exp_q.size() < DEPTH) exp_q.push_back({bm_ch, d});
            else exp_overrun = 1'b1;
          end
        end else begin
          bm_cnt = 0;
        end
      end else if (!bus.ADC_ENA) begin
        bm_rel++;
        if (bm_rel >= rel_hold) begin
          bus.ADC_FIN = 1'b0;
          bm_st = 0; bm_cnt = 0;
          bm_ch = (bm_ch == 3'd1) ? 3'd0 : bm_ch + 3'd1;
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge SYS_CLK);
    #1;
  endtask

  task automatic apply_reset();
    RUN = 1'b0; CLR_FLAGS = 1'b0;
    step();
    RSTbar = 1'b0;
    step(2);
    RSTbar = 1'b1;
    step();
  endtask

  task automatic pulse_clr();
    CLR_FLAGS = 1'b1;
    step();
    CLR_FLAGS = 1'b0;
    step();
  endtask

  task automatic test_reset();
    step();
    RSTbar = 1'b0;
    step(2);
    checks++; if (bus.ADC_ENA !== 1'b0) begin errors++; $display("[TB] FAIL rst_ena actual=%b expected=0", bus.ADC_ENA); end
    checks++; if (bus.ADC_DATA_MOSI !== 16'h0) begin errors++; $display("[TB] FAIL rst_mosi actual=%h expected=0", bus.ADC_DATA_MOSI); end
    checks++; if (bus.SAMPLE_VALID !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid actual=%b expected=0", bus.SAMPLE_VALID); end
    checks++; if (FIFO_COUNT !== 5'd0) begin errors++; $display("[TB] FAIL rst_count actual=%0d expected=0", FIFO_COUNT); end
    checks++; if ({bus.SAMPLE_CH, bus.SAMPLE_DATA} !== 19'd0) begin errors++; $display("[TB] FAIL rst_sample actual=%h/%h expected=0/0", bus.SAMPLE_CH, bus.SAMPLE_DATA); end
    checks++; if ({OVERRUN, LATE, TIMEOUT_ERR} !== 3'b000) begin errors++; $display("[TB] FAIL rst_flags actual=%b expected=000", {OVERRUN, LATE, TIMEOUT_ERR}); end
    RSTbar = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int i;
    apply_reset();
    miso_q.push_back(16'h0ABC);
    miso_q.push_back(16'h0DEF);
    ena_t.delete();
    bus.SAMPLE_READY = 1'b0;
    RUN = 1'b1;
    for (i = 0; i < 1000 && conv_fin < 2; i++) step();
    checks++; if (conv_fin < 2) begin errors++; $display("[TB] FAIL wait_basic_conv actual=%0d expected=2", conv_fin); end
    step(5);
    RUN = 1'b0;
    checks++; if (FIFO_COUNT !== 5'd2) begin errors++; $display("[TB] FAIL basic_count actual=%0d expected=2", FIFO_COUNT); end
    checks++; if ({bus.SAMPLE_CH, bus.SAMPLE_DATA} !== {3'd0, 16'h0ABC}) begin errors++; $display("[TB] FAIL basic_head actual=%h/%h expected=0/0abc", bus.SAMPLE_CH, bus.SAMPLE_DATA); end
    checks++;
    if (ena_t.size() < 2) begin errors++; $display("[TB] FAIL tick_spacing actual=%0d requests expected=2", ena_t.size()); end
    else if (ena_t[1] - ena_t[0] != 260) begin errors++; $display("[TB] FAIL tick_spacing actual=%0d expected=260", ena_t[1] - ena_t[0]); end
    bus.SAMPLE_READY = 1'b1;
    for (i = 0; i < 20 && bus.SAMPLE_VALID; i++) step();
    bus.SAMPLE_READY = 1'b0;
    checks++; if (FIFO_COUNT !== 5'd0) begin errors++; $display("[TB] FAIL basic_drain actual=%0d expected=0", FIFO_COUNT); end
  endtask

  task automatic test_overrun();
    int i;
    apply_reset();
    next_data = 16'h1000;
    conv_fin = 0;
    RUN = 1'b1;
    for (i = 0; i < 5000 && conv_fin < 17; i++) step();
    checks++; if (conv_fin < 17) begin errors++; $display("[TB] FAIL wait_17_conv actual=%0d expected=17", conv_fin); end
    step(5);
    RUN = 1'b0;
    step(5);
    checks++; if (FIFO_COUNT !== 5'd16) begin errors++; $display("[TB] FAIL ovr_count actual=%0d expected=16", FIFO_COUNT); end
    checks++; if (OVERRUN !== 1'b1) begin errors++; $display("[TB] FAIL ovr_flag actual=%b expected=1", OVERRUN); end
    checks++; if ({bus.SAMPLE_CH, bus.SAMPLE_DATA} !== {3'd0, 16'h1000}) begin errors++; $display("[TB] FAIL ovr_head actual=%h/%h expected=0/1000", bus.SAMPLE_CH, bus.SAMPLE_DATA); end
  endtask

  task automatic test_full_push_pop();
    int i;
    pulse_clr();
    checks++; if (OVERRUN !== 1'b0) begin errors++; $display("[TB] FAIL clr_overrun actual=%b expected=0", OVERRUN); end
    sync_pop = 1'b1;
    RUN = 1'b1;
    for (i = 0; i < 400 && conv_fin < 18; i++) step();
    checks++; if (conv_fin < 18) begin errors++; $display("[TB] FAIL wait_push_pop actual=%0d expected=18", conv_fin); end
    step(5);
    RUN = 1'b0;
    sync_pop = 1'b0;
    step(3);
    checks++; if (FIFO_COUNT !== 5'd16) begin errors++; $display("[TB] FAIL pp_count actual=%0d expected=16", FIFO_COUNT); end
    checks++; if (OVERRUN !== 1'b0) begin errors++; $display("[TB] FAIL pp_overrun actual=%b expected=0", OVERRUN); end
    checks++; if ({bus.SAMPLE_CH, bus.SAMPLE_DATA} !== {3'd1, 16'h1001}) begin errors++; $display("[TB] FAIL pp_head actual=%h/%h expected=1/1001", bus.SAMPLE_CH, bus.SAMPLE_DATA); end
    bus.SAMPLE_READY = 1'b1;
    for (i = 0; i < 40 && bus.SAMPLE_VALID; i++) step();
    bus.SAMPLE_READY = 1'b0;
    checks++; if (FIFO_COUNT !== 5'd0) begin errors++; $display("[TB] FAIL pp_drain actual=%0d expected=0", FIFO_COUNT); end
  endtask

  task automatic test_timeout();
    int i;
    int n;
    apply_reset();
    next_data = 16'h2000;
    fin_hang = 1'b1;
    RUN = 1'b1;
    for (i = 0; i < 400 && !bus.ADC_ENA; i++) step();
    RUN = 1'b0;
    n = 0;
    while (bus.ADC_ENA && n < 400) begin
      step();
      n++;
      if (n == 200) begin
        checks++; if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("[TB] FAIL to_early actual=%b expected=0", TIMEOUT_ERR); end
      end
    end
    checks++; if (n != 256) begin errors++; $display("[TB] FAIL to_ena_cycles actual=%0d expected=256", n); end
    checks++; if (TIMEOUT_ERR !== 1'b1) begin errors++; $display("[TB] FAIL to_flag actual=%b expected=1", TIMEOUT_ERR); end
    checks++; if (FIFO_COUNT !== 5'd0) begin errors++; $display("[TB] FAIL to_count actual=%0d expected=0", FIFO_COUNT); end
    fin_hang = 1'b0;
    conv_fin = 0;
    RUN = 1'b1;
    for (i = 0; i < 600 && conv_fin < 1; i++) step();
    step(5);
    RUN = 1'b0;
    checks++; if ({bus.SAMPLE_CH, bus.SAMPLE_DATA} !== {3'd0, 16'h2000}) begin errors++; $display("[TB] FAIL to_retry actual=%h/%h expected=0/2000", bus.SAMPLE_CH, bus.SAMPLE_DATA); end
    checks++; if (TIMEOUT_ERR !== 1'b1) begin errors++; $display("[TB] FAIL to_sticky actual=%b expected=1", TIMEOUT_ERR); end
    pulse_clr();
    checks++; if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("[TB] FAIL to_clear actual=%b expected=0", TIMEOUT_ERR); end
  endtask

  task automatic test_late();
    int i;
    apply_reset();
    ena_rises = 0;
    bus.SAMPLE_READY = 1'b1;
    fin_delay = 200;
    rel_hold = 100;
    RUN = 1'b1;
    for (i = 0; i < 800 && !LATE; i++) step();
    RUN = 1'b0;
    checks++; if (LATE !== 1'b1) begin errors++; $display("[TB] FAIL late_set actual=%b expected=1", LATE); end
    step(300);
    checks++; if (ena_rises != 1) begin errors++; $display("[TB] FAIL late_discard actual=%0d expected=1", ena_rises); end
    checks++; if (FIFO_COUNT !== 5'd0) begin errors++; $display("[TB] FAIL late_count actual=%0d expected=0", FIFO_COUNT); end
    pulse_clr();
    checks++; if (LATE !== 1'b0) begin errors++; $display("[TB] FAIL late_clear actual=%b expected=0", LATE); end
    fin_delay = 3;
    rel_hold = 1;
    bus.SAMPLE_READY = 1'b0;
  endtask

  task automatic test_reset_mid();
    int i;
    apply_reset();
    ena_rises = 0;
    conv_fin = 0;
    RUN = 1'b1;
    for (i = 0; i < 400 && conv_fin < 1; i++) step();
    fin_hang = 1'b1;
    for (i = 0; i < 400 && ena_rises < 2; i++) step();
    step(10);
    checks++; if ({bus.ADC_ENA, FIFO_COUNT} !== {1'b1, 5'd1}) begin errors++; $display("[TB] FAIL mid_pre actual=%b/%0d expected=1/1", bus.ADC_ENA, FIFO_COUNT); end
    #2;
    RSTbar = 1'b0;
    RUN = 1'b0;
    #1;
    checks++; if (bus.ADC_ENA !== 1'b0) begin errors++; $display("[TB] FAIL mid_ena actual=%b expected=0", bus.ADC_ENA); end
    checks++; if ({bus.SAMPLE_VALID, FIFO_COUNT} !== 6'd0) begin errors++; $display("[TB] FAIL mid_fifo actual=%b/%0d expected=0/0", bus.SAMPLE_VALID, FIFO_COUNT); end
    checks++; if ({bus.ADC_DATA_MOSI, bus.SAMPLE_CH, bus.SAMPLE_DATA} !== 35'd0) begin errors++; $display("[TB] FAIL mid_outputs actual=%h/%h/%h expected=0/0/0", bus.ADC_DATA_MOSI, bus.SAMPLE_CH, bus.SAMPLE_DATA); end
    checks++; if ({OVERRUN, LATE, TIMEOUT_ERR} !== 3'b000) begin errors++; $display("[TB] FAIL mid_flags actual=%b expected=000", {OVERRUN, LATE, TIMEOUT_ERR}); end
    step(2);
    RSTbar = 1'b1;
    fin_hang = 1'b0;
    step(2);
  endtask

  initial begin
    RSTbar = 1'b1;
    RUN = 1'b0;
    CLR_FLAGS = 1'b0;
    bus.ADC_FIN = 1'b0;
    bus.ADC_DATA_MISO = 16'h0;
    bus.SAMPLE_READY = 1'b0;
    test_reset();
    test_basic();
    test_overrun();
    test_full_push_pop();
    test_timeout();
    test_late();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
